writeback_unit: RTL and testbench

Write-back stage of the KGP-RISC datapath and the producing end of the register file's write port. It collects completed results from the ALU and the load unit through valid/ready handshakes, buffers them in a 2-entry in-order queue, and issues exactly one register-file write per cycle. To issue a write it drives the write-select, the write-data and the port-1 address override. While it holds port 1, the decode stage is stalled.

---
 rtl/kgp_risc_pkg.sv | 13 +
 rtl/wb_queue.sv | 39 +++
 rtl/writeback_unit.sv | 73 +++++++
 tb/tb_writeback_unit.sv | 132 +++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg: register-file write-select codes, link register and write-back queue types
package kgp_risc_pkg;
    localparam logic [1:0] WREG_NONE  = 2'b00;
    localparam logic [1:0] WREG_PORT1 = 2'b10;
    localparam logic [1:0] WREG_LINK  = 2'b11;
    localparam logic [4:0] LINK_REG   = 5'd31;
    typedef struct packed {
        logic        link;
        logic [4:0]  dest;
        logic [31:0] data;
    } wb_entry_t;
    typedef enum logic [1:0] {IDLE, ISSUE, FULL} wb_state_t;
endpackage

// File: rtl/wb_queue.sv
// wb_queue: 2-entry in-order FIFO, dual push (a before b), single pop
module wb_queue
    import kgp_risc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_a,
    input  wb_entry_t  entry_a,
    input  logic       push_b,
    input  wb_entry_t  entry_b,
    input  logic       pop,
    output wb_entry_t  head,
    output logic [1:0] count
);
    wb_entry_t  mem [2];
    logic       head_ptr, tail_ptr;
    logic [2:0] count_next;
    assign count_next = {1'b0, count} + {2'b0, push_a} + {2'b0, push_b} - {2'b0, pop};
    assign head = mem[head_ptr];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= 2'd0;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
        end else begin
            count    <= count_next[1:0];
            head_ptr <= head_ptr ^ pop;
            tail_ptr <= tail_ptr ^ (push_a ^ push_b);
        end
    end
    // a dual push lands b in the slot after a
    always_ff @(posedge clk) begin
        if (push_a) mem[tail_ptr] <= entry_a;
        if (push_b) mem[tail_ptr ^ push_a] <= entry_b;
    end
    always_ff @(posedge clk) begin
        if (rst) assert (count_next <= 3'd2);
    end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: accepts ALU/load results, queues them in order, issues one register-file write per cycle
module writeback_unit
    import kgp_risc_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        aluValid,
    output logic        aluReady,
    input  logic        aluLink,
    input  logic [4:0]  aluDest,
    input  logic [31:0] aluData,
    input  logic        memValid,
    output logic        memReady,
    input  logic [4:0]  memDest,
    input  logic [31:0] memData,
    output logic        wbActive,
    output logic [4:0]  wbAddr,
    output logic [1:0]  writeReg,
    output logic [31:0] writeData,
    output logic [1:0]  queueCount
);
    localparam logic [1:0] CAP = 2'(DEPTH);
    logic [1:0] sync;
    logic       rst_i;
    wb_state_t  state, state_next;
    logic       alu_push, mem_push, pop;
    logic [2:0] count_next;
    wb_entry_t  head;
    // assert asynchronously, release after two clean edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= 2'b00;
        else sync <= {sync[0], 1'b1};
    end
    assign rst_i    = sync[1];
    assign aluReady = rst_i && state != FULL;
    assign memReady = rst_i && (state == IDLE || (state == ISSUE && !aluValid));
    assign alu_push = aluValid && aluReady;
    assign mem_push = memValid && memReady;
    assign pop      = state != IDLE;
    always_comb begin
        count_next = 3'(state == FULL ? CAP : state == ISSUE ? 2'd1 : 2'd0)
                   + 3'(alu_push) + 3'(mem_push) - 3'(pop);
        state_next = count_next == 3'd0 ? IDLE : count_next == 3'd1 ? ISSUE : FULL;
    end
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            wbActive  <= 1'b0;
            writeReg  <= WREG_NONE;
            wbAddr    <= 5'd0;
            writeData <= 32'd0;
        end else begin
            state    <= state_next;
            wbActive <= pop;
            writeReg <= !pop ? WREG_NONE : head.link ? WREG_LINK : WREG_PORT1;
            wbAddr   <= !pop ? 5'd0 : head.link ? LINK_REG : head.dest;
            if (pop) writeData <= head.data;
        end
    end
    wb_queue u_queue (
        .clk     (clk),
        .rst     (rst_i),
        .push_a  (alu_push),
        .entry_a ({aluLink, aluDest, aluData}),
        .push_b  (mem_push),
        .entry_b ({1'b0, memDest, memData}),
        .pop     (pop),
        .head    (head),
        .count   (queueCount)
    );
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: randomized and directed checks against an in-order write queue model
module tb_writeback_unit;
    typedef struct packed {
        logic        link;
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;
    logic        clk = 1'b0, rst = 1'b0;
    logic        aluValid, aluReady, aluLink, memValid, memReady, wbActive;
    logic [4:0]  aluDest, memDest, wbAddr;
    logic [31:0] aluData, memData, writeData;
    logic [1:0]  writeReg, queueCount;
    logic [31:0] rf [32] = '{default: 32'd0};
    ent_t        q[$];
    logic        e_act;
    logic [1:0]  e_reg;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int          n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;
    writeback_unit dut (
        .clk(clk), .rst(rst),
        .aluValid(aluValid), .aluReady(aluReady), .aluLink(aluLink), .aluDest(aluDest), .aluData(aluData),
        .memValid(memValid), .memReady(memReady), .memDest(memDest), .memData(memData),
        .wbActive(wbActive), .wbAddr(wbAddr), .writeReg(writeReg), .writeData(writeData),
        .queueCount(queueCount)
    );
    // register file consuming the write port
    always @(posedge clk) begin
        if (writeReg == 2'b10) rf[wbAddr] <= writeData;
        else if (writeReg == 2'b11) rf[31] <= writeData;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic step(input logic av, input logic al, input logic [4:0] ad, input logic [31:0] adt,
                        input logic mv, input logic [4:0] md, input logic [31:0] mdt);
        logic ar, mr;
        ent_t e;
        int   cnt;
        cnt = q.size();
        aluValid = av; aluLink = al; aluDest = ad; aluData = adt;
        memValid = mv; memDest = md; memData = mdt;
        #1;
        ar = cnt < 2;
        mr = cnt == 0 || (cnt == 1 && !av);
        chk("alu_ready", 32'(aluReady), 32'(ar));
        chk("mem_ready", 32'(memReady), 32'(mr));
        e_act  = cnt > 0;
        e_reg  = 2'b00;
        e_addr = 5'd0;
        if (e_act) begin
            e      = q.pop_front();
            e_reg  = e.link ? 2'b11 : 2'b10;
            e_addr = e.link ? 5'd31 : e.dest;
            e_data = e.data;
        end
        if (av && ar) q.push_back({al, ad, adt});
        if (mv && mr) q.push_back({1'b0, md, mdt});
        @(negedge clk);
        chk("wb_active", 32'(wbActive), 32'(e_act));
        chk("write_reg", 32'(writeReg), 32'(e_reg));
        chk("wb_addr", 32'(wbAddr), 32'(e_addr));
        chk("write_data", writeData, e_data);
        chk("queue_count", 32'(queueCount), 32'(q.size()));
        chk("count_max", 32'(queueCount <= 2'd2), 32'd1);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask
    task automatic release_rst();
        aluValid = 1'b0;
        memValid = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 4 && aluReady !== 1'b1; k++) @(negedge clk);
        chk("rel_ready", 32'(aluReady), 32'd1);
        chk("rel_mem_ready", 32'(memReady), 32'd1);
        q.delete();
        e_data = 32'd0;
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        aluValid = 1'b1; aluLink = 1'b0; aluDest = 5'd9; aluData = 32'h55;
        memValid = 1'b0; memDest = 5'd0; memData = 32'd0;
        repeat (5) @(negedge clk);
        chk("rst_write_reg", 32'(writeReg), 32'd0);
        chk("rst_wb_active", 32'(wbActive), 32'd0);
        chk("rst_alu_ready", 32'(aluReady), 32'd0);
        chk("rst_mem_ready", 32'(memReady), 32'd0);
        chk("rst_write_data", writeData, 32'd0);
        chk("rst_count", 32'(queueCount), 32'd0);
        release_rst();
        step(1'b1, 1'b0, 5'd1, 32'd16, 1'b0, 5'd0, 32'd0);
        idle(2);
        chk("rf1", rf[1], 32'd16);
        step(1'b1, 1'b1, 5'd7, 32'd10, 1'b0, 5'd0, 32'd0);
        idle(2);
        chk("rf7_unchanged", rf[7], 32'd0);
        chk("rf31_link", rf[31], 32'd10);
        step(1'b1, 1'b0, 5'd2, 32'd22, 1'b1, 5'd3, 32'd9);
        idle(2);
        chk("rf2_first", rf[2], 32'd22);
        idle(1);
        chk("rf3_second", rf[3], 32'd9);
        repeat (8) step(1'b1, 1'($urandom), 5'($urandom), $urandom, 1'b1, 5'($urandom), $urandom);
        idle(3);
        repeat (80) step(1'($urandom), 1'($urandom), 5'($urandom), $urandom,
                         1'($urandom), 5'($urandom), $urandom);
        idle(3);
        step(1'b1, 1'b0, 5'd4, 32'd44, 1'b1, 5'd5, 32'd55);
        chk("mid_count_full", 32'(queueCount), 32'd2);
        rst = 1'b0;
        #1;
        chk("mid_write_reg", 32'(writeReg), 32'd0);
        chk("mid_wb_active", 32'(wbActive), 32'd0);
        chk("mid_count", 32'(queueCount), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_no_write", 32'(writeReg), 32'd0);
        end
        release_rst();
        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
